// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and encodings for the forwarding / hazard control block.
// Holds the operand-select codes, the shadow-pipeline entry type and the match helper.
package fwd_hazard_unit_pkg;

  localparam logic [1:0] SRC_REG = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_WR  = 2'b10;
  localparam logic [1:0] SRC_IMM = 2'b11;

  typedef struct packed {
    logic [4:0] rw;
    logic       regwr;
    logic       memtoreg;
  } shadow_e_t;

  localparam shadow_e_t SHADOW_BUBBLE = '{rw: 5'd0, regwr: 1'b0, memtoreg: 1'b0};

  // True when the entry will write register r. Callers must exclude r0 themselves.
  function automatic logic writes_reg(shadow_e_t e, logic [4:0] r);
    return e.regwr && (e.rw == r);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode-stage instruction fields presented to the forwarding / hazard unit.
// id_valid qualifies every other field; while the unit raises stall, decode holds these fields unchanged.
interface fwd_hazard_unit_if;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_use_imm;
  logic [4:0] id_rw;
  logic       id_regwr;
  logic       id_memtoreg;
  logic       id_mult;
  logic       id_rd_mult;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_use_imm,
           id_rw, id_regwr, id_memtoreg, id_mult, id_rd_mult
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_use_imm,
           id_rw, id_regwr, id_memtoreg, id_mult, id_rd_mult
  );
endinterface

// File: rtl/fwd_hazard_unit_fwd_select.sv
// Picks the source of one EX operand by comparing a decode register against the EX and MEM shadow entries.
// The newer producer (EX) wins; register 0 never forwards; use_imm forces the immediate.
module fwd_select
  import fwd_hazard_unit_pkg::*;
(
  input  logic [4:0] src,
  input  logic       use_src,
  input  logic       use_imm,
  input  shadow_e_t  ex_e,
  input  shadow_e_t  mem_e,
  output logic [1:0] sel
);

  always_comb begin
    sel = SRC_REG;
    if (use_imm) begin
      sel = SRC_IMM;
    end else if (use_src && (src != 5'd0)) begin
      if (writes_reg(ex_e, src)) begin
        sel = SRC_MEM;
      end else if (writes_reg(mem_e, src)) begin
        sel = SRC_WR;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and decode-stall generator: shadows the EX/MEM writers, registers next-cycle
// operand selects, and stalls decode on load-use and multiplier-busy hazards.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int MULT_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fwd_hazard_unit_if.slave     id,
  output logic [1:0]           ALUSrc_A,
  output logic [1:0]           ALUSrc_B,
  output logic                 stall,
  output logic                 ex_bubble,
  output logic                 mult_busy,
  output logic [3:0]           dbg_mcnt
);

  localparam logic [3:0] MULT_LAT_4 = 4'(MULT_LAT);

  shadow_e_t  ex_e;
  shadow_e_t  mem_e;
  logic [3:0] mcnt;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       load_use;
  logic       mult_hazard;
  logic       issue;

  fwd_select u_sel_a (
    .src     (id.id_rs),
    .use_src (id.id_use_rs),
    .use_imm (1'b0),
    .ex_e    (ex_e),
    .mem_e   (mem_e),
    .sel     (sel_a)
  );

  fwd_select u_sel_b (
    .src     (id.id_rt),
    .use_src (id.id_use_rt),
    .use_imm (id.id_use_imm),
    .ex_e    (ex_e),
    .mem_e   (mem_e),
    .sel     (sel_b)
  );

  // A load in EX cannot forward yet; its data only exists once it reaches MEM.
  always_comb begin
    load_use = 1'b0;
    if (ex_e.memtoreg && ex_e.regwr && (ex_e.rw != 5'd0)) begin
      load_use = (id.id_use_rs && (id.id_rs == ex_e.rw)) ||
                 (id.id_use_rt && !id.id_use_imm && (id.id_rt == ex_e.rw));
    end
  end

  assign mult_busy   = (mcnt != 4'd0);
  assign mult_hazard = mult_busy && (id.id_rd_mult || id.id_mult);
  assign stall       = id.id_valid && (load_use || mult_hazard);
  assign issue       = id.id_valid && !stall;
  assign dbg_mcnt    = mcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_e      <= SHADOW_BUBBLE;
      mem_e     <= SHADOW_BUBBLE;
      mcnt      <= 4'd0;
      ALUSrc_A  <= SRC_REG;
      ALUSrc_B  <= SRC_REG;
      ex_bubble <= 1'b1;
    end else begin
      mem_e <= ex_e;
      if (issue) begin
        ex_e      <= '{rw: id.id_rw, regwr: id.id_regwr, memtoreg: id.id_memtoreg};
        ALUSrc_A  <= sel_a;
        ALUSrc_B  <= sel_b;
        ex_bubble <= 1'b0;
      end else begin
        ex_e      <= SHADOW_BUBBLE;
        ALUSrc_A  <= SRC_REG;
        ALUSrc_B  <= SRC_REG;
        ex_bubble <= 1'b1;
      end
      if (issue && id.id_mult) begin
        mcnt <= MULT_LAT_4;
      end else if (mcnt != 4'd0) begin
        mcnt <= mcnt - 4'd1;
      end
    end
  end

endmodule
